// File: rtl/stg_if_pkg.sv
// Shared widths, FSM state codes and the bubble encoding for the instruction-fetch stage.
package stg_if_pkg;

    localparam int SIZE_ADDR = 16;
    localparam int SIZE_DATA = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [SIZE_DATA-1:0] INSTR_BUBBLE = {SIZE_DATA{1'b0}};
    localparam logic [SIZE_ADDR-1:0] PC_BUBBLE    = {SIZE_ADDR{1'b0}};

endpackage

// File: rtl/stg_if_skid.sv
// One-entry pc/instr holding register; parks a fetched word while the next stage stalls.
module if_skid
    import stg_if_pkg::*;
(
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [SIZE_ADDR-1:0] pc_in,
    input  logic [SIZE_DATA-1:0] instr_in,
    output logic                 valid,
    output logic [SIZE_ADDR-1:0] pc,
    output logic [SIZE_DATA-1:0] instr
);

    logic                 valid_r;
    logic [SIZE_ADDR-1:0] pc_r;
    logic [SIZE_DATA-1:0] instr_r;

    // Holding register; clear wins over load so a flush always empties the entry.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            valid_r <= 1'b0;
            pc_r    <= PC_BUBBLE;
            instr_r <= INSTR_BUBBLE;
        end else if (clear) begin
            valid_r <= 1'b0;
            pc_r    <= PC_BUBBLE;
            instr_r <= INSTR_BUBBLE;
        end else if (load) begin
            valid_r <= 1'b1;
            pc_r    <= pc_in;
            instr_r <= instr_in;
        end else begin
            valid_r <= valid_r;
            pc_r    <= pc_r;
            instr_r <= instr_r;
        end
    end

    assign valid = valid_r;
    assign pc    = pc_r;
    assign instr = instr_r;

endmodule

// File: rtl/stg_if.sv
// Instruction-fetch stage: drives a single-outstanding req/gnt/rvalid memory port and
// registers each fetched {pc, instr} for the expand stage, honouring flush and stall.
module stg_if
    import stg_if_pkg::*;
#(
    parameter logic [SIZE_ADDR-1:0] P_RESET_PC = {SIZE_ADDR{1'b0}},
    parameter logic [SIZE_ADDR-1:0] P_PC_STEP  = {{(SIZE_ADDR-1){1'b0}}, 1'b1}
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_flush,
    input  logic [SIZE_ADDR-1:0] iw_redirect_pc,
    input  logic                 iw_stall,
    output logic                 ow_imem_req,
    output logic [SIZE_ADDR-1:0] ow_imem_addr,
    input  logic                 iw_imem_gnt,
    input  logic                 iw_imem_rvalid,
    input  logic [SIZE_DATA-1:0] iw_imem_rdata,
    output logic [SIZE_ADDR-1:0] ow_pc,
    output logic [SIZE_DATA-1:0] ow_instr
);

    fetch_state_e         state_r, state_s;
    logic [SIZE_ADDR-1:0] pc_r, pc_s;
    logic [SIZE_ADDR-1:0] fetch_pc_r, fetch_pc_s;
    logic                 drop_r, drop_s;
    logic [SIZE_ADDR-1:0] out_pc_r, out_pc_s;
    logic [SIZE_DATA-1:0] out_instr_r, out_instr_s;
    logic                 skid_load_s, skid_clear_s, skid_valid_s;
    logic [SIZE_ADDR-1:0] skid_pc_s;
    logic [SIZE_DATA-1:0] skid_instr_s;
    logic                 deliver_s;
    logic [SIZE_ADDR-1:0] dlv_pc_s;
    logic [SIZE_DATA-1:0] dlv_instr_s;

    if_skid u_skid (
        .iw_clk   (iw_clk),
        .iw_rst   (iw_rst),
        .load     (skid_load_s),
        .clear    (skid_clear_s),
        .pc_in    (fetch_pc_r),
        .instr_in (iw_imem_rdata),
        .valid    (skid_valid_s),
        .pc       (skid_pc_s),
        .instr    (skid_instr_s)
    );

    // Next-state, PC and delivery decode; flush overrides every other event this cycle.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        fetch_pc_s   = fetch_pc_r;
        drop_s       = drop_r;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        deliver_s    = 1'b0;
        dlv_pc_s     = PC_BUBBLE;
        dlv_instr_s  = INSTR_BUBBLE;
        if (iw_flush) begin
            pc_s         = iw_redirect_pc;
            skid_clear_s = 1'b1;
            case (state_r)
                S_REQ: begin
                    if (iw_imem_gnt) begin
                        // The granted read still returns; mark it to be thrown away.
                        state_s = S_WAIT;
                        drop_s  = 1'b1;
                    end else begin
                        state_s = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (iw_imem_rvalid) begin
                        state_s = S_REQ;
                        drop_s  = 1'b0;
                    end else begin
                        state_s = S_WAIT;
                        drop_s  = 1'b1;
                    end
                end
                default: state_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_IDLE: state_s = S_REQ;
                S_REQ: begin
                    if (iw_imem_gnt) begin
                        fetch_pc_s = pc_r;
                        state_s    = S_WAIT;
                    end else begin
                        state_s = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (iw_imem_rvalid) begin
                        state_s = S_REQ;
                        if (drop_r) begin
                            drop_s = 1'b0;
                        end else if (!iw_stall) begin
                            deliver_s   = 1'b1;
                            dlv_pc_s    = fetch_pc_r;
                            dlv_instr_s = iw_imem_rdata;
                            pc_s        = fetch_pc_r + P_PC_STEP;
                        end else begin
                            skid_load_s = 1'b1;
                            state_s     = S_HOLD;
                        end
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!iw_stall) begin
                        deliver_s    = 1'b1;
                        dlv_pc_s     = skid_valid_s ? skid_pc_s : PC_BUBBLE;
                        dlv_instr_s  = skid_valid_s ? skid_instr_s : INSTR_BUBBLE;
                        pc_s         = pc_r + P_PC_STEP;
                        skid_clear_s = 1'b1;
                        state_s      = S_REQ;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Output latch: flush bubbles, a delivery loads, otherwise stall holds and idle bubbles.
    always_comb begin
        out_pc_s    = out_pc_r;
        out_instr_s = out_instr_r;
        if (iw_flush) begin
            out_pc_s    = PC_BUBBLE;
            out_instr_s = INSTR_BUBBLE;
        end else if (deliver_s) begin
            out_pc_s    = dlv_pc_s;
            out_instr_s = dlv_instr_s;
        end else if (iw_stall) begin
            out_pc_s    = out_pc_r;
            out_instr_s = out_instr_r;
        end else begin
            out_pc_s    = PC_BUBBLE;
            out_instr_s = INSTR_BUBBLE;
        end
    end

    // State, PC and output registers.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_r     <= S_IDLE;
            pc_r        <= P_RESET_PC;
            fetch_pc_r  <= PC_BUBBLE;
            drop_r      <= 1'b0;
            out_pc_r    <= PC_BUBBLE;
            out_instr_r <= INSTR_BUBBLE;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            fetch_pc_r  <= fetch_pc_s;
            drop_r      <= drop_s;
            out_pc_r    <= out_pc_s;
            out_instr_r <= out_instr_s;
        end
    end

    assign ow_imem_req  = (state_r == S_REQ);
    assign ow_imem_addr = ow_imem_req ? pc_r : PC_BUBBLE;
    assign ow_pc        = out_pc_r;
    assign ow_instr     = out_instr_r;

endmodule

// File: tb/tb_stg_if.sv
// Directed plus randomized bench for stg_if, checked each cycle against a transaction-level model.
module tb_stg_if;

    logic        iw_clk = 1'b0;
    logic        iw_rst = 1'b0;
    logic        iw_flush = 1'b0;
    logic [15:0] iw_redirect_pc = 16'h0000;
    logic        iw_stall = 1'b0;
    logic        ow_imem_req;
    logic [15:0] ow_imem_addr;
    logic        iw_imem_gnt = 1'b0;
    logic        iw_imem_rvalid = 1'b0;
    logic [31:0] iw_imem_rdata = 32'h0000_0000;
    logic [15:0] ow_pc;
    logic [31:0] ow_instr;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: idle cycle pending, read outstanding (+ whether it is doomed), parked word, next PC.
    bit          m_idle, m_out, m_drop, m_pend;
    logic [15:0] m_pc, m_fpc, m_ppc, m_opc;
    logic [31:0] m_pinstr, m_oinstr;
    logic [31:0] salt = 32'h0000_0000;

    stg_if #(.P_RESET_PC(16'h0010), .P_PC_STEP(16'h0001)) dut (
        .iw_clk         (iw_clk),
        .iw_rst         (iw_rst),
        .iw_flush       (iw_flush),
        .iw_redirect_pc (iw_redirect_pc),
        .iw_stall       (iw_stall),
        .ow_imem_req    (ow_imem_req),
        .ow_imem_addr   (ow_imem_addr),
        .iw_imem_gnt    (iw_imem_gnt),
        .iw_imem_rvalid (iw_imem_rvalid),
        .iw_imem_rdata  (iw_imem_rdata),
        .ow_pc          (ow_pc),
        .ow_instr       (ow_instr)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_req();
        return !m_idle && !m_out && !m_pend;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_pend = 1'b0;
        m_pc = 16'h0010; m_fpc = 16'h0000; m_ppc = 16'h0000;
        m_opc = 16'h0000; m_oinstr = 32'h0000_0000; m_pinstr = 32'h0000_0000;
    endtask

    task automatic check_all();
        chk("req", {31'h0, ow_imem_req}, {31'h0, m_req()});
        chk("addr", {16'h0, ow_imem_addr}, m_req() ? {16'h0, m_pc} : 32'h0000_0000);
        chk("ow_pc", {16'h0, ow_pc}, {16'h0, m_opc});
        chk("ow_instr", ow_instr, m_oinstr);
    endtask

    // One clock: check outputs, drive inputs, advance the model, move to the next falling edge.
    task automatic cyc(input bit fl, input logic [15:0] rd, input bit st, input bit g, input bit rv);
        bit          req;
        bit          dl;
        logic [15:0] dpc;
        logic [31:0] dins;
        logic [31:0] rdata;
        check_all();
        req   = m_req();
        dl    = 1'b0;
        dpc   = 16'h0000;
        dins  = 32'h0000_0000;
        rdata = rv ? ({16'h0, m_fpc} + 32'h0000_0100 + salt) : $urandom();
        iw_flush = fl; iw_redirect_pc = rd; iw_stall = st;
        iw_imem_gnt = g; iw_imem_rvalid = rv; iw_imem_rdata = rdata;
        if (fl) begin
            m_pend = 1'b0;
            if (m_out && rv) m_out = 1'b0;
            else if (m_out) m_drop = 1'b1;
            else if (req && g) begin m_out = 1'b1; m_drop = 1'b1; end
            m_idle = 1'b0; m_pc = rd; m_opc = 16'h0000; m_oinstr = 32'h0000_0000;
        end else begin
            if (m_idle) m_idle = 1'b0;
            else if (req && g) begin m_out = 1'b1; m_drop = 1'b0; m_fpc = m_pc; end
            else if (m_out && rv) begin
                m_out = 1'b0;
                if (!m_drop && !st) begin dl = 1'b1; dpc = m_fpc; dins = rdata; m_pc = m_fpc + 16'd1; end
                else if (!m_drop) begin m_pend = 1'b1; m_ppc = m_fpc; m_pinstr = rdata; end
                m_drop = 1'b0;
            end else if (m_pend && !st) begin
                dl = 1'b1; dpc = m_ppc; dins = m_pinstr; m_pend = 1'b0; m_pc = m_pc + 16'd1;
            end
            if (dl) begin m_opc = dpc; m_oinstr = dins; end
            else if (!st) begin m_opc = 16'h0000; m_oinstr = 32'h0000_0000; end
        end
        @(posedge iw_clk);
        @(negedge iw_clk);
    endtask

    // Memory that grants at once and answers one cycle later.
    task automatic auto(input int n, input bit st);
        repeat (n) cyc(1'b0, 16'h0000, st, m_req(), m_out);
    endtask

    initial begin
        model_reset();
        iw_rst = 1'b1;
        @(negedge iw_clk);
        chk("rst_req", {31'h0, ow_imem_req}, 32'h0000_0000);
        chk("rst_pc", {16'h0, ow_pc}, 32'h0000_0000);
        chk("rst_instr", ow_instr, 32'h0000_0000);
        @(negedge iw_clk);
        iw_rst = 1'b0;

        // Streaming from 0x10 with data = addr + 0x100.
        auto(5, 1'b0);
        chk("stream_pc", {16'h0, ow_pc}, 32'h0000_0011);
        chk("stream_instr", ow_instr, 32'h0000_0111);
        chk("stream_addr", {16'h0, ow_imem_addr}, 32'h0000_0012);

        // Grant withheld three cycles at 0x20.
        cyc(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            chk("gnt_wait_addr", {15'h0, ow_imem_req, ow_imem_addr}, 32'h0001_0020);
        end
        auto(2, 1'b0);
        chk("gnt_wait_pc", {16'h0, ow_pc}, 32'h0000_0020);
        chk("gnt_wait_instr", ow_instr, 32'h0000_0120);

        // Stall across the read return parks 0x21 until release.
        auto(4, 1'b1);
        chk("stall_hold_pc", {16'h0, ow_pc}, 32'h0000_0020);
        auto(1, 1'b0);
        chk("skid_pc", {16'h0, ow_pc}, 32'h0000_0021);
        chk("skid_next_addr", {16'h0, ow_imem_addr}, 32'h0000_0022);

        // Flush while waiting: the returning word is dropped.
        auto(1, 1'b0);
        cyc(1'b1, 16'h0080, 1'b0, 1'b0, 1'b0);
        chk("flush_wait_pc", {16'h0, ow_pc}, 32'h0000_0000);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("flush_redirect_addr", {15'h0, ow_imem_req, ow_imem_addr}, 32'h0001_0080);
        chk("flush_drop_instr", ow_instr, 32'h0000_0000);
        auto(2, 1'b0);
        chk("redirect_instr", ow_instr, 32'h0000_0180);

        // Flush together with stall clears a live output.
        cyc(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
        chk("flush_stall_instr", ow_instr, 32'h0000_0000);
        chk("flush_stall_addr", {16'h0, ow_imem_addr}, 32'h0000_0040);

        // PC wrap at the top of the address space.
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        auto(2, 1'b0);
        chk("wrap_pc", {16'h0, ow_pc}, 32'h0000_FFFF);
        chk("wrap_addr", {15'h0, ow_imem_req, ow_imem_addr}, 32'h0001_0000);

        // Asynchronous reset while a read is outstanding; its late rvalid must be ignored.
        auto(1, 1'b0);
        iw_imem_gnt = 1'b0;
        #2 iw_rst = 1'b1;
        #1;
        chk("async_rst_req", {31'h0, ow_imem_req}, 32'h0000_0000);
        chk("async_rst_out", ow_instr | {16'h0, ow_pc}, 32'h0000_0000);
        model_reset();
        @(negedge iw_clk);
        iw_rst = 1'b0;
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("restart_addr", {15'h0, ow_imem_req, ow_imem_addr}, 32'h0001_0010);

        // Randomized traffic: flushes, stalls, variable grant and return latency.
        for (int i = 0; i < 400; i++) begin
            salt = $urandom();
            cyc(($urandom_range(15) == 0), 16'($urandom()), ($urandom_range(3) == 0),
                m_req() && ($urandom_range(1) == 1), m_out && ($urandom_range(1) == 1));
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
